// File: rtl/operand_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : operand_request_sequencer
// Description : Per-queue VRF read sequencer upstream of the lane operand
//               queues. Accepts one operand-fetch request (base word address
//               plus word count) at a time, emits the matching operand-queue
//               command in the accept cycle, then issues one VRF read per
//               granted cycle. Issue is throttled by queue space and a
//               read-after-write hazard stall.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: ARA_OPREQ_PERF_CNT_EN
//   defined   : stall_cycles_o counts ISSUE cycles without a grant
//               (saturating, cleared only by reset)
//   undefined : stall_cycles_o tied to zero, no counter state
// ----------------------------------------------------------------------------
// Ports
//   clk_i                     in   clock
//   rst_ni                    in   synchronous active-low reset
//   req_addr_i                in   base VRF word address
//   req_len_i                 in   number of 64-bit words to read
//   req_valid_i               in   request valid
//   req_ready_o               out  idle, able to accept a request
//   operand_queue_cmd_len_o   out  word count forwarded to the queue
//   operand_queue_cmd_valid_o out  one-cycle command pulse (accept cycle)
//   operand_queue_ready_i     in   queue has room for one more operand
//   hazard_stall_i            in   RAW hazard pending, block issue
//   vrf_req_o                 out  read request to the bank arbiter
//   vrf_addr_o                out  current read word address
//   vrf_bank_o                out  target bank (low address bits)
//   vrf_gnt_i                 in   arbiter grant, same cycle as vrf_req_o
//   operand_issued_o          out  read granted this cycle
//   done_o                    out  registered one-cycle completion pulse
//   busy_o                    out  sequencer not idle
//   stall_cycles_o            out  performance counter
// ============================================================================
module operand_request_sequencer #(
    parameter int unsigned AddrWidth = 12,
    parameter int unsigned LenWidth  = 10,
    parameter int unsigned NrBanks   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [AddrWidth-1:0]       req_addr_i,
    input  logic [LenWidth-1:0]        req_len_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    output logic [LenWidth-1:0]        operand_queue_cmd_len_o,
    output logic                       operand_queue_cmd_valid_o,
    input  logic                       operand_queue_ready_i,
    input  logic                       hazard_stall_i,
    output logic                       vrf_req_o,
    output logic [AddrWidth-1:0]       vrf_addr_o,
    output logic [$clog2(NrBanks)-1:0] vrf_bank_o,
    input  logic                       vrf_gnt_i,
    output logic                       operand_issued_o,
    output logic                       done_o,
    output logic                       busy_o,
    output logic [31:0]                stall_cycles_o
);

    localparam int unsigned BANK_WIDTH = $clog2(NrBanks);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q,  addr_d;
    logic [LenWidth-1:0]  rem_q,   rem_d;
    logic                 done_q,  done_d;

    logic                 accept;
    logic                 grant;

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d                   = state_q;
        addr_d                    = addr_q;
        rem_d                     = rem_q;
        done_d                    = 1'b0;
        accept                    = 1'b0;
        grant                     = 1'b0;
        req_ready_o               = 1'b0;
        operand_queue_cmd_valid_o = 1'b0;
        operand_queue_cmd_len_o   = '0;
        vrf_req_o                 = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                accept      = req_valid_i;
                if (accept) begin
                    addr_d = req_addr_i;
                    rem_d  = req_len_i;
                    if (req_len_i != '0) begin
                        state_d                   = ISSUE;
                        operand_queue_cmd_valid_o = 1'b1;
                        operand_queue_cmd_len_o   = req_len_i;
                    end else begin
                        // Empty request: complete without touching the VRF
                        // or the queue.
                        done_d = 1'b1;
                    end
                end
            end

            ISSUE: begin
                vrf_req_o = operand_queue_ready_i & ~hazard_stall_i;
                // A grant seen while no request is raised is ignored.
                grant     = vrf_req_o & vrf_gnt_i;
                if (grant) begin
                    addr_d = addr_q + AddrWidth'(1);  // wraps modulo 2^AddrWidth
                    rem_d  = rem_q - LenWidth'(1);
                    if (rem_q == LenWidth'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign operand_issued_o = grant;
    assign vrf_addr_o       = addr_q;
    assign vrf_bank_o       = addr_q[BANK_WIDTH-1:0];
    assign done_o           = done_q;
    assign busy_o           = (state_q != IDLE);

    // ------------------------------------------------------------------------
    // Stall-cycle performance counter
    // ------------------------------------------------------------------------
`ifdef ARA_OPREQ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        // Any ISSUE cycle without a grant counts, whatever the cause;
        // the counter holds at all-ones rather than wrapping.
        if ((state_q == ISSUE) && !grant && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`else
    assign stall_cycles_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_request_sequencer
// Description : Directed self-checking bench for operand_request_sequencer.
//               Inputs change 1 ns after a rising edge; combinational outputs
//               are sampled mid-cycle, registered outputs after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_request_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [11:0] req_addr_i;
    logic [9:0]  req_len_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [9:0]  operand_queue_cmd_len_o;
    logic        operand_queue_cmd_valid_o;
    logic        operand_queue_ready_i;
    logic        hazard_stall_i;
    logic        vrf_req_o;
    logic [11:0] vrf_addr_o;
    logic [2:0]  vrf_bank_o;
    logic        vrf_gnt_i;
    logic        operand_issued_o;
    logic        done_o;
    logic        busy_o;
    logic [31:0] stall_cycles_o;

    int checks   = 0;
    int failures = 0;

    operand_request_sequencer #(
        .AddrWidth (12),
        .LenWidth  (10),
        .NrBanks   (8)
    ) dut (
        .clk_i                     (clk_i),
        .rst_ni                    (rst_ni),
        .req_addr_i                (req_addr_i),
        .req_len_i                 (req_len_i),
        .req_valid_i               (req_valid_i),
        .req_ready_o               (req_ready_o),
        .operand_queue_cmd_len_o   (operand_queue_cmd_len_o),
        .operand_queue_cmd_valid_o (operand_queue_cmd_valid_o),
        .operand_queue_ready_i     (operand_queue_ready_i),
        .hazard_stall_i            (hazard_stall_i),
        .vrf_req_o                 (vrf_req_o),
        .vrf_addr_o                (vrf_addr_o),
        .vrf_bank_o                (vrf_bank_o),
        .vrf_gnt_i                 (vrf_gnt_i),
        .operand_issued_o          (operand_issued_o),
        .done_o                    (done_o),
        .busy_o                    (busy_o),
        .stall_cycles_o            (stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef ARA_OPREQ_PERF_CNT_EN
    localparam logic [31:0] EXP_BP_STALLS = 32'd4;
`else
    localparam logic [31:0] EXP_BP_STALLS = 32'd0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Backpressure stimulus per ISSUE cycle: qready, hazard, gnt, expected issue
    logic [3:0] bp_tab [0:6];
    logic [7:0] b2b_cycle;
    int         issued_cnt;
    logic [11:0] exp_addr;

    initial begin
        bp_tab[0] = 4'b0_0_1_0;  // queue full, stray grant ignored
        bp_tab[1] = 4'b0_0_1_0;  // queue full
        bp_tab[2] = 4'b1_0_1_1;  // grant word 0
        bp_tab[3] = 4'b1_1_1_0;  // hazard
        bp_tab[4] = 4'b1_0_0_0;  // arbiter loss
        bp_tab[5] = 4'b1_0_1_1;  // grant word 1
        bp_tab[6] = 4'b1_0_1_1;  // grant word 2

        rst_ni                = 1'b0;
        req_addr_i            = '0;
        req_len_i             = '0;
        req_valid_i           = 1'b0;
        operand_queue_ready_i = 1'b0;
        hazard_stall_i        = 1'b0;
        vrf_gnt_i             = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;

        // ---------------- Reset state ----------------
        settle();
        check("rst_ready", {31'd0, req_ready_o}, 32'd1);
        check("rst_busy",  {31'd0, busy_o}, 32'd0);
        check("rst_done",  {31'd0, done_o}, 32'd0);
        check("rst_vrfreq", {31'd0, vrf_req_o}, 32'd0);
        check("rst_cmdv",  {31'd0, operand_queue_cmd_valid_o}, 32'd0);
        check("rst_addr",  {20'd0, vrf_addr_o}, 32'd0);
        check("rst_stall", stall_cycles_o, 32'd0);
        tick();

        // ---------------- Basic: addr 0x010, len 4 ----------------
        operand_queue_ready_i = 1'b1;
        vrf_gnt_i             = 1'b1;
        req_addr_i            = 12'h010;
        req_len_i             = 10'd4;
        req_valid_i           = 1'b1;
        settle();
        check("basic_cmdv",   {31'd0, operand_queue_cmd_valid_o}, 32'd1);
        check("basic_cmdlen", {22'd0, operand_queue_cmd_len_o}, 32'd4);
        check("basic_vrfreq_accept", {31'd0, vrf_req_o}, 32'd0);
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("basic_issued", {31'd0, operand_issued_o}, 32'd1);
            check("basic_addr", {20'd0, vrf_addr_o}, 32'h010 + i);
            check("basic_bank", {29'd0, vrf_bank_o}, i);
            check("basic_ready", {31'd0, req_ready_o}, 32'd0);
            check("basic_done_early", {31'd0, done_o}, 32'd0);
            tick();
        end
        settle();
        check("basic_done",  {31'd0, done_o}, 32'd1);
        check("basic_busy",  {31'd0, busy_o}, 32'd0);
        check("basic_stall", stall_cycles_o, 32'd0);
        tick();
        settle();
        check("basic_done_pulse", {31'd0, done_o}, 32'd0);
        tick();

        // ---------------- Backpressure: addr 0x020, len 3 ----------------
        req_addr_i  = 12'h020;
        req_len_i   = 10'd3;
        req_valid_i = 1'b1;
        settle();
        check("bp_cmdlen", {22'd0, operand_queue_cmd_len_o}, 32'd3);
        tick();
        req_valid_i = 1'b0;
        issued_cnt  = 0;
        for (int c = 0; c < 7; c++) begin
            operand_queue_ready_i = bp_tab[c][3];
            hazard_stall_i        = bp_tab[c][2];
            vrf_gnt_i             = bp_tab[c][1];
            settle();
            check("bp_issued", {31'd0, operand_issued_o}, {31'd0, bp_tab[c][0]});
            check("bp_vrfreq", {31'd0, vrf_req_o}, {31'd0, bp_tab[c][3] & ~bp_tab[c][2]});
            check("bp_addr", {20'd0, vrf_addr_o}, 32'h020 + issued_cnt);
            if (operand_issued_o) issued_cnt++;
            tick();
        end
        operand_queue_ready_i = 1'b1;
        hazard_stall_i        = 1'b0;
        vrf_gnt_i             = 1'b1;
        settle();
        check("bp_count", issued_cnt, 32'd3);
        check("bp_done",  {31'd0, done_o}, 32'd1);
        check("bp_stall", stall_cycles_o, EXP_BP_STALLS);
        check("bp_vrfreq_after", {31'd0, vrf_req_o}, 32'd0);
        tick();

        // ---------------- Wrap: addr 0xFFE, len 4 ----------------
        req_addr_i  = 12'hFFE;
        req_len_i   = 10'd4;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        exp_addr    = 12'hFFE;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("wrap_addr", {20'd0, vrf_addr_o}, {20'd0, exp_addr});
            check("wrap_bank", {29'd0, vrf_bank_o}, {29'd0, exp_addr[2:0]});
            exp_addr = exp_addr + 12'd1;
            tick();
        end
        settle();
        check("wrap_done", {31'd0, done_o}, 32'd1);
        tick();

        // ---------------- Zero length ----------------
        req_addr_i  = 12'h055;
        req_len_i   = 10'd0;
        req_valid_i = 1'b1;
        settle();
        check("zero_cmdv",  {31'd0, operand_queue_cmd_valid_o}, 32'd0);
        check("zero_ready", {31'd0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 1'b0;
        settle();
        check("zero_done",   {31'd0, done_o}, 32'd1);
        check("zero_ready2", {31'd0, req_ready_o}, 32'd1);
        check("zero_vrfreq", {31'd0, vrf_req_o}, 32'd0);
        check("zero_busy",   {31'd0, busy_o}, 32'd0);
        check("zero_stall",  stall_cycles_o, EXP_BP_STALLS);
        tick();

        // ---------------- Back-to-back: len 2 then len 1 ----------------
        req_addr_i  = 12'h100;
        req_len_i   = 10'd2;
        req_valid_i = 1'b1;
        settle();
        check("b2b_cmd1", {22'd0, operand_queue_cmd_len_o}, 32'd2);
        tick();
        req_addr_i = 12'h200;
        req_len_i  = 10'd1;
        issued_cnt = 0;
        // Cycles 1..2: first request issues, second is held off.
        for (int i = 0; i < 2; i++) begin
            settle();
            check("b2b_hold_ready", {31'd0, req_ready_o}, 32'd0);
            check("b2b_hold_cmdv", {31'd0, operand_queue_cmd_valid_o}, 32'd0);
            check("b2b_addr1", {20'd0, vrf_addr_o}, 32'h100 + i);
            if (operand_issued_o) issued_cnt++;
            tick();
        end
        // Cycle 3: done of first request, second accepted.
        settle();
        check("b2b_done1", {31'd0, done_o}, 32'd1);
        check("b2b_cmd2v", {31'd0, operand_queue_cmd_valid_o}, 32'd1);
        check("b2b_cmd2",  {22'd0, operand_queue_cmd_len_o}, 32'd1);
        tick();
        req_valid_i = 1'b0;
        settle();
        check("b2b_addr2", {20'd0, vrf_addr_o}, 32'h200);
        if (operand_issued_o) issued_cnt++;
        tick();
        settle();
        check("b2b_reads", issued_cnt, 32'd3);
        check("b2b_done2", {31'd0, done_o}, 32'd1);
        tick();

        // ---------------- Reset mid-operation ----------------
        req_addr_i  = 12'h300;
        req_len_i   = 10'd5;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();  // grant 1
        tick();  // grant 2
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        settle();
        check("mid_busy",   {31'd0, busy_o}, 32'd0);
        check("mid_ready",  {31'd0, req_ready_o}, 32'd1);
        check("mid_vrfreq", {31'd0, vrf_req_o}, 32'd0);
        check("mid_done",   {31'd0, done_o}, 32'd0);
        check("mid_stall",  stall_cycles_o, 32'd0);
        tick();
        settle();
        check("mid_done2",  {31'd0, done_o}, 32'd0);
        check("mid_vrfreq2", {31'd0, vrf_req_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Unused helper register kept driven to avoid X in any trace view.
    initial b2b_cycle = 8'd0;

endmodule
`default_nettype wire
